// File: rtl/ag_video_pkg.sv
// Shared timing constants for the Agat VGA raster path (640x480@60 defaults).
package ag_video_pkg;

  localparam int DEF_H_VISIBLE    = 640;
  localparam int DEF_H_FRONT      = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BACK       = 48;
  localparam int DEF_V_VISIBLE    = 480;
  localparam int DEF_V_FRONT      = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BACK       = 33;
  localparam int DEF_FLASH_FRAMES = 12;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  localparam int HPOS_W = 10;
  localparam int VPOS_W = 9;

  function automatic bit timing_legal(input int h_total, input int v_total,
                                      input int v_visible, input int flash_frames);
    return (h_total <= 1024) && (v_total <= 1024) && (v_visible <= 512) &&
           (flash_frames >= 1) && (flash_frames <= 16);
  endfunction

endpackage

// File: rtl/ag_sync_counter.sv
// Wrapping up-counter 0..MAX with a terminal-count flag; advances only when en is high.
module ag_sync_counter #(
  parameter int W   = 10,
  parameter int MAX = 799
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = MAX[W-1:0];

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ag_video_timing.sv
// VGA raster timing for the Agat video path: syncs, visible window, positions,
// line/frame strobes and the text flash phase, all registered off the raster counters.
module ag_video_timing
  import ag_video_pkg::*;
#(
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter bit HS_ACTIVE    = 1'b0,
  parameter bit VS_ACTIVE    = 1'b0,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic              clk25,
  input  logic              rst_n,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              line_start,
  output logic              frame_start,
  output logic              flash
);

  localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSYNC_ON    = H_VISIBLE + H_FRONT;
  localparam int HSYNC_OFF   = HSYNC_ON + H_SYNC;
  localparam int VSYNC_ON    = V_VISIBLE + V_FRONT;
  localparam int VSYNC_OFF   = VSYNC_ON + V_SYNC;
  localparam logic [3:0] FC_RELOAD = 4'(FLASH_FRAMES - 1);

  if (!timing_legal(LINE_LEN, FRAME_LINES, V_VISIBLE, FLASH_FRAMES)) begin : g_bad_timing
    $error("ag_video_timing: illegal timing parameters");
  end

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_tc;
  logic       v_tc;
  logic       unused_frame_tc;
  logic [3:0] fc;

  ag_sync_counter #(.W(10), .MAX(LINE_LEN - 1)) u_hcnt (
    .clk   (clk25),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (h_cnt),
    .tc    (h_tc)
  );

  ag_sync_counter #(.W(10), .MAX(FRAME_LINES - 1)) u_vcnt (
    .clk   (clk25),
    .rst_n (rst_n),
    .en    (h_tc),
    .cnt   (v_cnt),
    .tc    (v_tc)
  );

  assign unused_frame_tc = v_tc;

  logic in_hs;
  logic in_vs;
  logic vis;
  logic sol;
  logic sof;

  assign in_hs = (int'(h_cnt) >= HSYNC_ON) && (int'(h_cnt) < HSYNC_OFF);
  assign in_vs = (int'(v_cnt) >= VSYNC_ON) && (int'(v_cnt) < VSYNC_OFF);
  assign vis   = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
  assign sol   = (h_cnt == '0);
  assign sof   = sol && (v_cnt == '0);

  // Decode stage: every output is a registered view of the current counter position.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      hsync       <= ~HS_ACTIVE;
      vsync       <= ~VS_ACTIVE;
      video_on    <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      flash       <= 1'b0;
      fc          <= '0;
    end else begin
      hsync       <= in_hs ? HS_ACTIVE : ~HS_ACTIVE;
      vsync       <= in_vs ? VS_ACTIVE : ~VS_ACTIVE;
      video_on    <= vis;
      hpos        <= vis ? h_cnt : '0;
      vpos        <= vis ? v_cnt[VPOS_W-1:0] : '0;
      line_start  <= sol;
      frame_start <= sof;
      // fc starts at 0 so the first frame after reset flips the phase at once.
      if (sof) begin
        if (fc == '0) begin
          fc    <= FC_RELOAD;
          flash <= ~flash;
        end else begin
          fc <= fc - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ag_video_timing.sv
// Directed bench: a default 640x480 instance and a shrunken-raster instance share clock and reset.
module tb_ag_video_timing;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;

  logic       hsync_f, vsync_f, video_on_f, line_start_f, frame_start_f, flash_f;
  logic [9:0] hpos_f;
  logic [8:0] vpos_f;
  logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s, flash_s;
  logic [9:0] hpos_s;
  logic [8:0] vpos_s;

  int ncmp  = 0;
  int nfail = 0;

  always #20 clk25 = ~clk25;

  ag_video_timing u_full (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .hsync       (hsync_f),
    .vsync       (vsync_f),
    .video_on    (video_on_f),
    .hpos        (hpos_f),
    .vpos        (vpos_f),
    .line_start  (line_start_f),
    .frame_start (frame_start_f),
    .flash       (flash_f)
  );

  // 25 clocks per line, 13 lines per frame (325 clocks), active-high syncs.
  ag_video_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b1), .FLASH_FRAMES(12)
  ) u_small (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .video_on    (video_on_s),
    .hpos        (hpos_s),
    .vpos        (vpos_s),
    .line_start  (line_start_s),
    .frame_start (frame_start_s),
    .flash       (flash_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int f_hs_first, f_hs_last, f_hs_cnt, f_ls_cnt, f_vs_cnt;
    int s_hs_first, s_hs_cnt, s_vs_first, s_vs_cnt, s_vid_cnt, s_ls_cnt;
    int fs_cnt, fs_last, gap_bad, ntog;
    int tog_frame[8];
    logic fl_prev;

    f_hs_first = -1; f_hs_last = -1; f_hs_cnt = 0; f_ls_cnt = 0; f_vs_cnt = 0;
    s_hs_first = -1; s_hs_cnt = 0; s_vs_first = -1; s_vs_cnt = 0; s_vid_cnt = 0; s_ls_cnt = 0;
    fs_cnt = 0; fs_last = -1; gap_bad = 0; ntog = 0; fl_prev = 1'b0;
    for (int i = 0; i < 8; i++) tog_frame[i] = -1;

    rst_n = 1'b0;
    repeat (4) @(negedge clk25);
    chk("rst_hsync_f", hsync_f, 1);
    chk("rst_vsync_f", vsync_f, 1);
    chk("rst_video_on_f", video_on_f, 0);
    chk("rst_hpos_f", hpos_f, 0);
    chk("rst_vpos_f", vpos_f, 0);
    chk("rst_line_start_f", line_start_f, 0);
    chk("rst_frame_start_f", frame_start_f, 0);
    chk("rst_flash_f", flash_f, 0);
    chk("rst_hsync_s", hsync_s, 0);
    chk("rst_vsync_s", vsync_s, 0);
    chk("rst_video_on_s", video_on_s, 0);
    chk("rst_flash_s", flash_s, 0);

    rst_n = 1'b1;
    for (int n = 0; n < 9750; n++) begin
      @(negedge clk25);
      // default-timing instance
      if (n < 800 && hsync_f == 1'b0) begin
        f_hs_cnt++;
        if (f_hs_first < 0) f_hs_first = n;
        f_hs_last = n;
      end
      if (n < 1600 && line_start_f) f_ls_cnt++;
      if (vsync_f == 1'b0) f_vs_cnt++;
      if (n == 0) begin
        chk("first_video_on_f", video_on_f, 1);
        chk("first_hpos_f", hpos_f, 0);
        chk("first_vpos_f", vpos_f, 0);
        chk("first_line_start_f", line_start_f, 1);
        chk("first_frame_start_f", frame_start_f, 1);
        chk("first_flash_f", flash_f, 1);
        chk("first_frame_start_s", frame_start_s, 1);
        chk("first_video_on_s", video_on_s, 1);
      end
      if (n == 1) begin
        chk("n1_line_start_f", line_start_f, 0);
        chk("n1_frame_start_f", frame_start_f, 0);
        chk("n1_hpos_f", hpos_f, 1);
      end
      if (n == 639) begin
        chk("n639_video_on_f", video_on_f, 1);
        chk("n639_hpos_f", hpos_f, 639);
      end
      if (n == 640) begin
        chk("n640_video_on_f", video_on_f, 0);
        chk("n640_hpos_f", hpos_f, 0);
      end
      if (n == 800) begin
        chk("line1_line_start_f", line_start_f, 1);
        chk("line1_frame_start_f", frame_start_f, 0);
        chk("line1_hpos_f", hpos_f, 0);
        chk("line1_vpos_f", vpos_f, 1);
      end

      // shrunken-raster instance
      if (frame_start_s) begin
        if (fs_last >= 0 && n - fs_last != 325) gap_bad++;
        fs_last = n;
        fs_cnt++;
      end
      if (flash_s !== fl_prev) begin
        if (ntog < 8) tog_frame[ntog] = fs_cnt - 1;
        ntog++;
        fl_prev = flash_s;
      end
      if (n < 25 && hsync_s) begin
        s_hs_cnt++;
        if (s_hs_first < 0) s_hs_first = n;
      end
      if (n < 325) begin
        if (vsync_s) begin
          s_vs_cnt++;
          if (s_vs_first < 0) s_vs_first = n;
        end
        if (video_on_s) s_vid_cnt++;
        if (line_start_s) s_ls_cnt++;
      end
      if (n == 15) begin
        chk("s_h15_video_on", video_on_s, 1);
        chk("s_h15_hpos", hpos_s, 15);
      end
      if (n == 16) chk("s_h16_video_on", video_on_s, 0);
      if (n == 175) begin
        chk("s_line7_video_on", video_on_s, 1);
        chk("s_line7_vpos", vpos_s, 7);
        chk("s_line7_hpos", hpos_s, 0);
      end
      if (n == 180) begin
        chk("s_line7_h5_hpos", hpos_s, 5);
        chk("s_line7_h5_vpos", vpos_s, 7);
      end
      if (n == 200) begin
        chk("s_line8_video_on", video_on_s, 0);
        chk("s_line8_vpos", vpos_s, 0);
      end
      if (n == 324) begin
        chk("s_last_frame_start", frame_start_s, 0);
        chk("s_last_video_on", video_on_s, 0);
      end
      if (n == 325) begin
        chk("s_wrap_frame_start", frame_start_s, 1);
        chk("s_wrap_line_start", line_start_s, 1);
        chk("s_wrap_video_on", video_on_s, 1);
        chk("s_wrap_vpos", vpos_s, 0);
      end
    end

    chk("hsync_f_first", f_hs_first, 656);
    chk("hsync_f_last", f_hs_last, 751);
    chk("hsync_f_width", f_hs_cnt, 96);
    chk("line_start_f_count", f_ls_cnt, 2);
    chk("vsync_f_idle", f_vs_cnt, 0);
    chk("flash_f_held", flash_f, 1);
    chk("hsync_s_first", s_hs_first, 18);
    chk("hsync_s_width", s_hs_cnt, 4);
    chk("vsync_s_first", s_vs_first, 225);
    chk("vsync_s_width", s_vs_cnt, 50);
    chk("video_on_s_count", s_vid_cnt, 128);
    chk("line_start_s_count", s_ls_cnt, 13);
    chk("frame_start_s_count", fs_cnt, 30);
    chk("frame_start_s_gaps", gap_bad, 0);
    chk("flash_s_toggles", ntog, 3);
    chk("flash_s_tog0", tog_frame[0], 0);
    chk("flash_s_tog1", tog_frame[1], 12);
    chk("flash_s_tog2", tog_frame[2], 24);
    chk("flash_s_final", flash_s, 1);

    // Run into the middle of a frame, then abort it with a 3-clock reset.
    repeat (84) @(negedge clk25);
    chk("pre_rst_hpos_s", hpos_s, 8);
    chk("pre_rst_vpos_s", vpos_s, 3);
    chk("pre_rst_hpos_f", hpos_f, 233);
    chk("pre_rst_vpos_f", vpos_f, 12);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk25);
      chk("mid_rst_hsync_f", hsync_f, 1);
      chk("mid_rst_vsync_f", vsync_f, 1);
      chk("mid_rst_video_on_f", video_on_f, 0);
      chk("mid_rst_hsync_s", hsync_s, 0);
      chk("mid_rst_video_on_s", video_on_s, 0);
      chk("mid_rst_flash_s", flash_s, 0);
      chk("mid_rst_line_start_f", line_start_f, 0);
    end
    rst_n = 1'b1;
    @(negedge clk25);
    chk("restart_frame_start_f", frame_start_f, 1);
    chk("restart_line_start_f", line_start_f, 1);
    chk("restart_video_on_f", video_on_f, 1);
    chk("restart_hpos_f", hpos_f, 0);
    chk("restart_vpos_f", vpos_f, 0);
    chk("restart_flash_f", flash_f, 1);
    chk("restart_frame_start_s", frame_start_s, 1);
    chk("restart_flash_s", flash_s, 1);
    @(negedge clk25);
    chk("restart_n1_hpos_s", hpos_s, 1);
    chk("restart_n1_frame_start_s", frame_start_s, 0);
    chk("restart_n1_flash_s", flash_s, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
